// File: rtl/if_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one outstanding imem fetch, and presents words to the decoder.
// Latency: rvalid in cycle N gives instr_valid in cycle N+1. With zero-wait memory the loop is REQ -> WAIT -> HOLD.
// Backpressure: HOLD stalls while instr_ready=0 and no new request is issued. Optional IF_MISALIGN_CHK_EN adds the ERR state.
module if_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] HOLD = 3'd3;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        iv_q, iv_d;
    logic [31:0] iout_q, iout_d;
    logic [31:0] ipc_q, ipc_d;

    // Redirect target and where the FSM goes once a redirect (or a pending kill) resolves.
    logic [31:0] tgt;
    logic [2:0]  after_redir;
    logic [2:0]  after_kill;

`ifdef IF_MISALIGN_CHK_EN
    localparam logic [2:0] ERR = 3'd4;

    assign tgt         = redirect_pc;
    // A misaligned target never fetches; pc keeps the bad value so a deferred kill still lands in ERR.
    assign after_redir = (|redirect_pc[1:0]) ? ERR : REQ;
    assign after_kill  = (|pc_q[1:0]) ? ERR : REQ;
    assign fetch_err   = (state_q == ERR);
`else
    logic unused_low_bits;

    assign tgt             = {redirect_pc[31:2], 2'b00};
    assign after_redir     = REQ;
    assign after_kill      = REQ;
    assign fetch_err       = 1'b0;
    assign unused_low_bits = |redirect_pc[1:0];
`endif

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = iv_q;
    assign instr_out   = iout_q;
    assign instr_pc    = ipc_q;

    // Next-state logic; redirect takes priority over gnt/rvalid/ready in every state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        iv_d    = iv_q;
        iout_d  = iout_q;
        ipc_d   = ipc_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d    = tgt;
                    state_d = after_redir;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    pc_d = tgt;
                    if (imem_gnt) begin
                        // Old address was already granted: its response must be dropped.
                        kill_d  = 1'b1;
                        state_d = WAIT;
                    end else begin
                        state_d = after_redir;
                    end
                end else if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d = tgt;
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = after_redir;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = after_kill;
                    end else begin
                        iout_d  = imem_rdata;
                        ipc_d   = pc_q;
                        iv_d    = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = tgt;
                    iv_d    = 1'b0;
                    state_d = after_redir;
                end else if (instr_ready) begin
                    pc_d    = pc_q + 32'd4;
                    iv_d    = 1'b0;
                    state_d = REQ;
                end
            end
`ifdef IF_MISALIGN_CHK_EN
            ERR: begin
                if (redirect) begin
                    pc_d    = tgt;
                    state_d = after_redir;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            iv_q    <= 1'b0;
            iout_q  <= 32'h0;
            ipc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            iv_q    <= iv_d;
            iout_q  <= iout_d;
            ipc_q   <= ipc_d;
        end
    end

endmodule

// File: tb/tb_if_ctrl.sv
// Directed bench for if_ctrl: memory responses are driven step by step and expected (pc, word) pairs go through a scoreboard.
// Latency: each delivered word is expected in HOLD the cycle after its rvalid.
// Backpressure: instr_ready is held low for chosen cycle counts to check stalls.
module tb_if_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    int errors = 0;
    int checks = 0;

    logic [63:0] sb[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_dat;

    if_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a request and check its address.
    task automatic wait_req(input logic [31:0] addr, input string tag);
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick();
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, addr);
    endtask

    // Drive one fetch from request through rvalid; leaves the DUT in HOLD with the word checked.
    task automatic fetch_to_hold(input logic [31:0] addr, input int gdly, input int rdly,
                                 input logic [31:0] data, input string tag);
        wait_req(addr, tag);
        for (int i = 0; i < gdly; i++) begin
            tick();
            chk({tag, "_addr_hold"}, imem_addr, addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk({tag, "_req_low_wait"}, {31'd0, imem_req}, 32'd0);
        for (int i = 1; i < rdly; i++) begin
            tick();
            chk({tag, "_no_valid_wait"}, {31'd0, instr_valid}, 32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        sb.push_back({addr, data});
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            {exp_pc, exp_dat} = sb.pop_front();
            chk({tag, "_instr_pc"}, instr_pc, exp_pc);
            chk({tag, "_instr_out"}, instr_out, exp_dat);
        end
    endtask

    // Stall for stall cycles, then consume.
    task automatic consume(input int stall, input string tag);
        instr_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, "_stall_valid"}, {31'd0, instr_valid}, 32'd1);
            chk({tag, "_stall_pc"}, instr_pc, exp_pc);
            chk({tag, "_stall_out"}, instr_out, exp_dat);
            chk({tag, "_stall_noreq"}, {31'd0, imem_req}, 32'd0);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_out", instr_out, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("first_req", {31'd0, imem_req}, 32'd1);

        // Zero-wait sequential fetches.
        fetch_to_hold(32'h0, 0, 1, 32'h0000_0013, "seq0");
        consume(0, "seq0");
        fetch_to_hold(32'h4, 0, 1, 32'h0000_0013, "seq4");
        consume(0, "seq4");
        fetch_to_hold(32'h8, 0, 1, 32'h0000_0013, "seq8");
        consume(0, "seq8");

        // Slow memory: gnt after 3 cycles, rvalid 2 cycles after gnt.
        fetch_to_hold(32'hC, 3, 2, 32'h0010_0093, "slow");
        consume(0, "slow");

        // Decoder stall in HOLD, then pc advances.
        fetch_to_hold(32'h10, 0, 1, 32'h0020_0113, "stall");
        consume(5, "stall");
        wait_req(32'h14, "after_stall");

        // Redirect in WAIT, rvalid later: data discarded, refetch from 0x100.
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("kill_noreq", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("kill_novalid", {31'd0, instr_valid}, 32'd0);
        fetch_to_hold(32'h100, 0, 1, 32'h0030_0193, "redir100");
        consume(0, "redir100");

        // Redirect and rvalid in the same WAIT cycle.
        wait_req(32'h104, "pre_same");
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h180;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        redirect    = 1'b0;
        imem_rvalid = 1'b0;
        chk("same_novalid", {31'd0, instr_valid}, 32'd0);
        fetch_to_hold(32'h180, 0, 1, 32'h0040_0213, "redir180");
        consume(0, "redir180");

        // Redirect together with instr_ready in HOLD.
        fetch_to_hold(32'h184, 0, 1, 32'h0050_0293, "hold184");
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        instr_ready = 1'b1;
        tick();
        redirect    = 1'b0;
        instr_ready = 1'b0;
        chk("hold_redir_drop", {31'd0, instr_valid}, 32'd0);
        fetch_to_hold(32'h200, 0, 1, 32'h0060_0313, "redir200");
        consume(0, "redir200");

        // Misaligned redirect while requesting.
        wait_req(32'h204, "pre_mis");
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
        chk("mis_err", {31'd0, fetch_err}, 32'd1);
        chk("mis_noreq", {31'd0, imem_req}, 32'd0);
        tick();
        tick();
        chk("mis_err_held", {31'd0, fetch_err}, 32'd1);
        chk("mis_noreq_held", {31'd0, imem_req}, 32'd0);
        chk("mis_novalid", {31'd0, instr_valid}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h104;
        tick();
        redirect = 1'b0;
        chk("mis_err_clear", {31'd0, fetch_err}, 32'd0);
        fetch_to_hold(32'h104, 0, 1, 32'h0070_0393, "mis_recover");
        consume(0, "mis_recover");
`else
        chk("align_err", {31'd0, fetch_err}, 32'd0);
        fetch_to_hold(32'h100, 0, 1, 32'h0070_0393, "align100");
        consume(0, "align100");
`endif

        // Reset while waiting for data, then a late rvalid.
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick();
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("wrst_req", {31'd0, imem_req}, 32'd0);
        chk("wrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("wrst_pc", instr_pc, 32'h0);
        chk("wrst_out", instr_out, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFEED_F00D;
        tick();
        imem_rvalid = 1'b0;
        chk("late_novalid", {31'd0, instr_valid}, 32'd0);
        fetch_to_hold(32'h0, 0, 1, 32'h0080_0413, "restart");
        consume(0, "restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
